// File: rtl/vpu_linebuffer_nbank.sv
// ============================================================================
// vpu_linebuffer_nbank
// ----------------------------------------------------------------------------
// N-bank rotating line buffer between the sprite compositor (port B,
// read/write) and the display scan-out (port A, read-only). The compositor
// always works on the current write bank. Display scan-out reads the line
// that was completed most recently.
//
// Each swap pulse advances the write bank round-robin. The bank that was just
// written becomes the display bank.
//
// A sequenced clear engine writes CLR_VAL into one entry per cycle:
//   - After reset, it sweeps all banks in parallel.
//   - On clear_req, it sweeps the current write bank.
// Port B is held off (b_ready low) while the clear engine runs.
//
// Ports
//   clk_i          clock
//   rst_ni         asynchronous active-low reset
//   swap_i         line boundary pulse, advances the write bank
//   clear_req_i    starts a clear of the current write bank (ignored if busy)
//   clear_busy_o   clear engine active (reset sweep or requested clear)
//   clear_done_o   one-cycle pulse on the last entry of a completed sweep
//   clear_abort_o  sticky, a clear was cut short by swap; reset by clear_req
//   wr_bank_o      current compositor bank
//   rd_bank_o      current display bank
//   a_en_i         display read strobe
//   a_addr_i       display read address
//   a_dout_o       display read data, one cycle after a_en_i
//   a_valid_o      a_dout_o valid (registered a_en_i)
//   b_ready_o      port B can accept an access
//   b_en_i         compositor access strobe
//   b_we_i         compositor write enable
//   b_addr_i       compositor address
//   b_din_i        compositor write data
//   b_dout_o       compositor read data (contents before the write)
//
// Configuration macro
//   VPU_LB_TRANSPARENT_EN
//     When defined, a port B write whose low byte is zero is suppressed
//     (palette index 0 is transparent). The old entry is still returned.
// ============================================================================
module vpu_linebuffer_nbank #(
    parameter int                DATA_W  = 32,
    parameter int                DEPTH   = 320,
    parameter int                NBANK   = 2,
    parameter int                ADDR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter int                BANK_W  = (NBANK > 1) ? $clog2(NBANK) : 1,
    parameter logic [DATA_W-1:0] CLR_VAL = '0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              swap_i,
    input  logic              clear_req_i,
    output logic              clear_busy_o,
    output logic              clear_done_o,
    output logic              clear_abort_o,
    output logic [BANK_W-1:0] wr_bank_o,
    output logic [BANK_W-1:0] rd_bank_o,
    input  logic              a_en_i,
    input  logic [ADDR_W-1:0] a_addr_i,
    output logic [DATA_W-1:0] a_dout_o,
    output logic              a_valid_o,
    output logic              b_ready_o,
    input  logic              b_en_i,
    input  logic              b_we_i,
    input  logic [ADDR_W-1:0] b_addr_i,
    input  logic [DATA_W-1:0] b_din_i,
    output logic [DATA_W-1:0] b_dout_o
);

    localparam logic [ADDR_W-1:0] LAST_PTR  = ADDR_W'(DEPTH - 1);
    localparam logic [BANK_W-1:0] LAST_BANK = BANK_W'(NBANK - 1);
    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  clrPtr_q, clrPtr_d;
    logic [BANK_W-1:0]  wrBank_q, wrBank_d;
    logic [BANK_W-1:0]  rdBank_q, rdBank_d;
    logic               abort_q, abort_d;
    logic [DATA_W-1:0]  aDout_q;
    logic               aValid_q;
    logic [DATA_W-1:0]  bDout_q;

    logic [BANK_W-1:0]  nextBank;
    logic               clrWrite;
    logic               clrAll;
    logic               clearDone;
    logic               aInRange;
    logic               bInRange;
    logic               bAccept;
    logic               bLands;
    logic               bWrite;

    logic [DATA_W-1:0]  mem [NBANK][DEPTH];

    // Round-robin successor of the write bank. NBANK need not be a power of
    // two, so the wrap is explicit rather than relying on counter overflow.
    always_comb begin
        nextBank = (wrBank_q == LAST_BANK) ? '0 : wrBank_q + 1'b1;
    end

    // Addresses at or beyond DEPTH fall outside every bank. Such reads return
    // zero, and such writes are dropped. Port B is only served while the
    // clear engine is idle, so the two never write the same bank at once.
`ifdef VPU_LB_TRANSPARENT_EN
    // Palette index 0 is transparent, so a write carrying it leaves the
    // pixel underneath untouched.
    always_comb begin
        bLands = (b_din_i[7:0] != 8'd0);
    end
`else
    // Every accepted write lands.
    always_comb begin
        bLands = 1'b1;
    end
`endif

    // Range checks and port B acceptance/write qualification.
    always_comb begin
        aInRange = ({1'b0, a_addr_i} < DEPTH_EXT);
        bInRange = ({1'b0, b_addr_i} < DEPTH_EXT);
        bAccept  = b_en_i && (state_q == ST_IDLE);
        bWrite   = bAccept && b_we_i && bInRange && bLands;
    end

    // Clear sequencing and bank rotation.
    // Swaps are ignored during the reset sweep. A swap during a requested
    // clear aborts it on that very cycle, so the entry under the pointer
    // keeps its old value and no done pulse is produced. A swap and a
    // clear_req arriving together rotate first. The clear then starts on the
    // following cycle against the new write bank.
    always_comb begin
        state_d   = state_q;
        clrPtr_d  = clrPtr_q;
        wrBank_d  = wrBank_q;
        rdBank_d  = rdBank_q;
        abort_d   = abort_q;
        clrWrite  = 1'b0;
        clrAll    = 1'b0;
        clearDone = 1'b0;
        unique case (state_q)
            ST_INIT: begin
                clrWrite = 1'b1;
                clrAll   = 1'b1;
                if (clrPtr_q == LAST_PTR) begin
                    state_d   = ST_IDLE;
                    clrPtr_d  = '0;
                    clearDone = 1'b1;
                end else begin
                    clrPtr_d = clrPtr_q + 1'b1;
                end
            end
            ST_IDLE: begin
                if (swap_i) begin
                    wrBank_d = nextBank;
                    rdBank_d = wrBank_q;
                end
                if (clear_req_i) begin
                    state_d  = ST_CLEAR;
                    clrPtr_d = '0;
                    abort_d  = 1'b0;
                end
            end
            ST_CLEAR: begin
                if (swap_i) begin
                    wrBank_d = nextBank;
                    rdBank_d = wrBank_q;
                    state_d  = ST_IDLE;
                    clrPtr_d = '0;
                    abort_d  = 1'b1;
                end else begin
                    clrWrite = 1'b1;
                    if (clrPtr_q == LAST_PTR) begin
                        state_d   = ST_IDLE;
                        clrPtr_d  = '0;
                        clearDone = 1'b1;
                    end else begin
                        clrPtr_d = clrPtr_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d  = ST_INIT;
                clrPtr_d = '0;
            end
        endcase
    end

    // Control registers.
    // Reset lands in the full-buffer sweep with the display one bank behind
    // the compositor.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_INIT;
            clrPtr_q <= '0;
            wrBank_q <= '0;
            rdBank_q <= LAST_BANK;
            abort_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            clrPtr_q <= clrPtr_d;
            wrBank_q <= wrBank_d;
            rdBank_q <= rdBank_d;
            abort_q  <= abort_d;
        end
    end

    // Bank storage, deliberately without reset so it can map onto RAM.
    // Contents become defined through the sweep that follows every reset.
    always_ff @(posedge clk_i) begin
        if (clrWrite) begin
            if (clrAll) begin
                for (int b = 0; b < NBANK; b++) begin
                    mem[b][clrPtr_q] <= CLR_VAL;
                end
            end else begin
                mem[wrBank_q][clrPtr_q] <= CLR_VAL;
            end
        end else if (bWrite) begin
            mem[wrBank_q][b_addr_i] <= b_din_i;
        end
    end

    // Read-data registers for both ports.
    // Port B samples the entry before this cycle's write lands. This gives
    // read-before-write, and back-to-back writes to one address return the
    // earlier value. Both data registers hold when their port is not
    // serviced.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            aDout_q  <= '0;
            aValid_q <= 1'b0;
            bDout_q  <= '0;
        end else begin
            aValid_q <= a_en_i;
            if (a_en_i) begin
                aDout_q <= aInRange ? mem[rdBank_q][a_addr_i] : '0;
            end
            if (bAccept) begin
                bDout_q <= bInRange ? mem[wrBank_q][b_addr_i] : '0;
            end
        end
    end

    // Output assignments.
    always_comb begin
        clear_busy_o  = (state_q != ST_IDLE);
        clear_done_o  = clearDone;
        clear_abort_o = abort_q;
        wr_bank_o     = wrBank_q;
        rd_bank_o     = rdBank_q;
        a_dout_o      = aDout_q;
        a_valid_o     = aValid_q;
        b_ready_o     = (state_q == ST_IDLE);
        b_dout_o      = bDout_q;
    end

endmodule

// File: tb/tb_vpu_linebuffer_nbank.sv
// ============================================================================
// tb_vpu_linebuffer_nbank
// ----------------------------------------------------------------------------
// Bench for vpu_linebuffer_nbank with three banks of 24 entries. The depth is
// deliberately not a power of two, so the out-of-range addresses 24..31 are
// reachable.
//
// A behavioural model tracks:
//   - the bank contents,
//   - the sweep in progress (none, reset sweep, or requested clear),
//   - the bank indices.
// A compare process checks every DUT output against the model on each
// falling edge. Directed sequences pin literal values. A randomized phase
// then exercises the design against the model.
// ============================================================================
module tb_vpu_linebuffer_nbank;

    localparam int DW = 32;
    localparam int D  = 24;
    localparam int NB = 3;
    localparam int AW = 5;
    localparam int BW = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          swap = 1'b0;
    logic          clearReq = 1'b0;
    logic          clearBusy;
    logic          clearDone;
    logic          clearAbort;
    logic [BW-1:0] wrBank;
    logic [BW-1:0] rdBank;
    logic          aEn = 1'b0;
    logic [AW-1:0] aAddr = '0;
    logic [DW-1:0] aDout;
    logic          aValid;
    logic          bReady;
    logic          bEn = 1'b0;
    logic          bWe = 1'b0;
    logic [AW-1:0] bAddr = '0;
    logic [DW-1:0] bDin = '0;
    logic [DW-1:0] bDout;

    int nChecks = 0;
    int nFails  = 0;
    int doneSeen = 0;

    vpu_linebuffer_nbank #(
        .DATA_W (DW),
        .DEPTH  (D),
        .NBANK  (NB)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .swap_i        (swap),
        .clear_req_i   (clearReq),
        .clear_busy_o  (clearBusy),
        .clear_done_o  (clearDone),
        .clear_abort_o (clearAbort),
        .wr_bank_o     (wrBank),
        .rd_bank_o     (rdBank),
        .a_en_i        (aEn),
        .a_addr_i      (aAddr),
        .a_dout_o      (aDout),
        .a_valid_o     (aValid),
        .b_ready_o     (bReady),
        .b_en_i        (bEn),
        .b_we_i        (bWe),
        .b_addr_i      (bAddr),
        .b_din_i       (bDin),
        .b_dout_o      (bDout)
    );

    // 10 ns clock period.
    always #5 clk = ~clk;

    // Model state.
    // mBusy encodes the sweep in progress:
    //   0 = none, 1 = reset sweep of every bank, 2 = requested clear of the
    //   write bank.
    int          mBusy, mPtr, mWr, mRd, oldBusy;
    bit          mAbort, mAvalid;
    logic [31:0] mAdout, mBdout;
    logic [31:0] mMem [NB][D];

    // Whether an accepted write actually lands in the bank.
    function automatic bit lands(input logic [31:0] d);
`ifdef VPU_LB_TRANSPARENT_EN
        return d[7:0] != 8'd0;
`else
        return 1'b1;
`endif
    endfunction

    // Behavioural model, advanced on each rising edge.
    // Within one edge the reads happen first, then the writes, then the
    // bank/sweep bookkeeping.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mBusy = 1; mPtr = 0; mWr = 0; mRd = NB - 1;
            mAbort = 0; mAvalid = 0; mAdout = 0; mBdout = 0;
        end else begin
            oldBusy = mBusy;
            mAvalid = aEn;
            if (aEn) mAdout = (int'(aAddr) < D) ? mMem[mRd][aAddr] : 32'h0;
            if (bEn && oldBusy == 0) begin
                if (int'(bAddr) < D) begin
                    mBdout = mMem[mWr][bAddr];
                    if (bWe && lands(bDin)) mMem[mWr][bAddr] = bDin;
                end else begin
                    mBdout = 0;
                end
            end
            if (oldBusy == 1) begin
                for (int b = 0; b < NB; b++) mMem[b][mPtr] = 0;
                if (mPtr == D - 1) begin mBusy = 0; mPtr = 0; end
                else mPtr++;
            end else if (oldBusy == 2) begin
                if (swap) begin
                    mRd = mWr; mWr = (mWr + 1) % NB; mBusy = 0; mPtr = 0; mAbort = 1;
                end else begin
                    mMem[mWr][mPtr] = 0;
                    if (mPtr == D - 1) begin mBusy = 0; mPtr = 0; end
                    else mPtr++;
                end
            end else begin
                if (swap) begin mRd = mWr; mWr = (mWr + 1) % NB; end
                if (clearReq) begin mBusy = 2; mPtr = 0; mAbort = 0; end
            end
        end
    end

    // Single comparison point: counts the check and reports a mismatch.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (clearDone) doneSeen++;
        checkOutput("wr_bank",     32'(wrBank),     32'(mWr));
        checkOutput("rd_bank",     32'(rdBank),     32'(mRd));
        checkOutput("clear_busy",  32'(clearBusy),  32'(mBusy != 0));
        checkOutput("b_ready",     32'(bReady),     32'(mBusy == 0));
        checkOutput("clear_done",  32'(clearDone),
                    32'(mBusy != 0 && mPtr == D - 1 && !(mBusy == 2 && swap)));
        checkOutput("clear_abort", 32'(clearAbort), 32'(mAbort));
        checkOutput("a_valid",     32'(aValid),     32'(mAvalid));
        checkOutput("a_dout",      aDout,           mAdout);
        checkOutput("b_dout",      bDout,           mBdout);
    end

    // Drive one cycle of inputs shortly after the rising edge.
    task automatic applyStimulus(input logic sw, input logic cr, input logic ae,
                                 input logic [AW-1:0] aa, input logic be, input logic bw,
                                 input logic [AW-1:0] ba, input logic [DW-1:0] bd);
        @(posedge clk);
        #1;
        swap = sw; clearReq = cr; aEn = ae; aAddr = aa;
        bEn = be; bWe = bw; bAddr = ba; bDin = bd;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic doReset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        swap = 0; clearReq = 0; aEn = 0; bEn = 0; bWe = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Port A read with a literal expectation.
    task automatic readA(input logic [AW-1:0] addr, input logic [DW-1:0] exp, input string name);
        applyStimulus(1'b0, 1'b0, 1'b1, addr, 1'b0, 1'b0, '0, '0);
        idle();
        checkOutput(name, aDout, exp);
        checkOutput({name, "_valid"}, 32'(aValid), 32'd1);
    endtask

    // Port B write; the returned old contents are left in bDout.
    task automatic writeB(input logic [AW-1:0] addr, input logic [DW-1:0] data);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b1, addr, data);
        idle();
    endtask

    task automatic doSwap();
        applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0);
        idle();
    endtask

    // Bounded wait for the clear engine to go idle.
    task automatic waitIdle(input string name);
        int n;
        n = 0;
        while (clearBusy && n < 100) begin
            idle();
            n++;
        end
        checkOutput({name, "_timeout"}, 32'(clearBusy), 32'd0);
    endtask

    // Watchdog.
    initial begin
        #1ms;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    int busyCnt, doneBase;
    logic [DW-1:0] exp6;

    // Directed sequences followed by the randomized phase.
    initial begin
        // Reset values and the reset sweep length.
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_wr_bank", 32'(wrBank), 32'd0);
        checkOutput("rst_rd_bank", 32'(rdBank), 32'd2);
        checkOutput("rst_busy",    32'(clearBusy), 32'd1);
        checkOutput("rst_ready",   32'(bReady), 32'd0);
        rst_n = 1'b1;
        busyCnt = 0;
        doneBase = doneSeen;
        repeat (D + 2) begin
            @(negedge clk);
            #1;
            if (clearBusy) busyCnt++;
        end
        checkOutput("init_busy_cycles", 32'(busyCnt), 32'(D));
        checkOutput("init_done_pulses", 32'(doneSeen - doneBase), 32'd1);

        // All banks read zero. Three swaps walk the banks round-robin.
        for (int k = 0; k < NB; k++) begin
            for (int a = 0; a < D; a++) readA(AW'(a), 32'h0, "init_zero");
            doSwap();
            checkOutput("rot_wr_bank", 32'(wrBank), 32'((k + 1) % NB));
            checkOutput("rot_rd_bank", 32'(rdBank), 32'(k));
        end

        // Write, swap, then read back through the display port.
        writeB(5'd5, 32'h00AB_CD12);
        doSwap();
        checkOutput("t2_rd_bank", 32'(rdBank), 32'd0);
        checkOutput("t2_wr_bank", 32'(wrBank), 32'd1);
        readA(5'd5, 32'h00AB_CD12, "t2_a_dout");

        // Clear cut short by a swap after ten cycles.
        for (int a = 0; a < D; a++)
            applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b1, AW'(a), 32'hA500_0000 | 32'(a + 1));
        idle();
        doneBase = doneSeen;
        applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0, '0, '0);
        repeat (10) idle();
        doSwap();
        checkOutput("t4_abort", 32'(clearAbort), 32'd1);
        checkOutput("t4_no_done", 32'(doneSeen - doneBase), 32'd0);
        checkOutput("t4_rd_bank", 32'(rdBank), 32'd1);
        readA(5'd0, 32'h0, "t4_addr0");
        readA(5'd9, 32'h0, "t4_addr9");
        readA(5'd10, 32'hA500_000B, "t4_addr10");
        readA(5'd23, 32'hA500_0018, "t4_addr23");

        // Out-of-range accesses; port B held off during a clear.
        writeB(5'd24, 32'h5555_5555);
        checkOutput("t5_oor_b_dout", bDout, 32'h0);
        readA(5'd24, 32'h0, "t5_oor_a_dout");
        applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0, '0, '0);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b1, 5'd3, 32'hDEAD_BEEF);
        checkOutput("t5_ready_busy", 32'(bReady), 32'd0);
        checkOutput("t5_abort_clr", 32'(clearAbort), 32'd0);
        idle();
        waitIdle("t5_clear");
        doSwap();
        readA(5'd3, 32'h0, "t5_addr3");

        // Transparent write and back-to-back writes to one address.
        writeB(5'd7, 32'h0000_0077);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b1, 5'd7, 32'h1234_5600);
        idle();
        checkOutput("t6_b2b_old", bDout, 32'h0000_0077);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0, 5'd7, '0);
        idle();
`ifdef VPU_LB_TRANSPARENT_EN
        exp6 = 32'h0000_0077;
`else
        exp6 = 32'h1234_5600;
`endif
        checkOutput("t6_entry", bDout, exp6);

        // Reset in the middle of a clear restarts the full sweep.
        applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0, '0, '0);
        repeat (5) idle();
        doReset();
        checkOutput("rst_mid_wr", 32'(wrBank), 32'd0);
        checkOutput("rst_mid_rd", 32'(rdBank), 32'd2);
        doneBase = doneSeen;
        repeat (D + 2) idle();
        checkOutput("rst_mid_done", 32'(doneSeen - doneBase), 32'd1);

        // Randomized traffic checked by the model.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 599) == 0) begin
                doReset();
            end else begin
                applyStimulus($urandom_range(0, 39) == 0,
                              $urandom_range(0, 19) == 0,
                              (mBusy != 1) && ($urandom_range(0, 1) == 1),
                              AW'($urandom_range(0, 31)),
                              $urandom_range(0, 1) == 1,
                              $urandom_range(0, 1) == 1,
                              AW'($urandom_range(0, 31)),
                              ($urandom_range(0, 3) == 0) ? ($urandom() & 32'hFFFF_FF00) : $urandom());
            end
        end
        idle();
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
